// File: rtl/rx_frame_buffer_writer.sv
// Ingress frame writer: stores MAC bytes in a circular buffer,
// commits good frames and queues one descriptor per committed frame.
module rx_frame_buffer_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUF_DEPTH    = 2048,
  parameter int DESC_DEPTH   = 8,
  parameter int MIN_FRAME    = 64,
  parameter int GRANT_MARGIN = 4,
  parameter int CNT_W        = 16,
  localparam int ADDR_W      = $clog2(BUF_DEPTH)
) (
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic [DATA_WIDTH-1:0] frame_data_i,
  input  logic                  frame_valid_i,
  input  logic                  frame_sof_i,
  input  logic                  frame_eof_i,
  input  logic                  frame_error_i,
  input  logic [47:0]           mac_dst_addr_i,
  input  logic [47:0]           mac_src_addr_i,
  output logic                  frame_grant_o,
  output logic                  desc_valid_o,
  input  logic                  desc_ready_i,
  output logic [ADDR_W-1:0]     desc_start_o,
  output logic [10:0]           desc_len_o,
  output logic [47:0]           desc_dst_o,
  output logic [47:0]           desc_src_o,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  release_i,
  input  logic [10:0]           release_len_i,
  output logic [CNT_W-1:0]      stat_ok_o,
  output logic [CNT_W-1:0]      stat_drop_o
);

  localparam int P  = ADDR_W + 1;
  localparam int DW = $clog2(DESC_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t state;
  logic [P-1:0] wr_ptr;
  logic [P-1:0] commit_ptr;
  logic [P-1:0] free_ptr;
  logic [P-1:0] used;
  logic [P-1:0] free;
  logic [ADDR_W-1:0] start_ptr;
  logic [10:0] len;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  logic [ADDR_W-1:0] d_start [DESC_DEPTH];
  logic [10:0]       d_len   [DESC_DEPTH];
  logic [47:0]       d_dst   [DESC_DEPTH];
  logic [47:0]       d_src   [DESC_DEPTH];
  logic [DW:0]       d_wr;
  logic [DW:0]       d_rd;

  logic accept, pop, full, room;
  logic in_write, good, restart;
  logic begin_f, append, wen;
  logic [ADDR_W-1:0] waddr;

  assign used   = wr_ptr - free_ptr;
  assign free   = P'(BUF_DEPTH) - used;
  assign accept = frame_valid_i && frame_grant_o;

  assign full = (d_wr[DW] != d_rd[DW]) &&
                (d_wr[DW-1:0] == d_rd[DW-1:0]);
  assign desc_valid_o = (d_wr != d_rd);
  assign pop  = desc_valid_o && desc_ready_i;
  // a same-cycle pop frees the slot the push needs
  assign room = !full || pop;

  assign in_write = (state == WRITE) && !frame_eof_i;
  assign good = (state == WRITE) && frame_eof_i &&
                !frame_error_i && room &&
                (len >= 11'(MIN_FRAME));
  assign restart = in_write && accept && frame_sof_i;
  assign begin_f = (state == IDLE) && accept &&
                   frame_sof_i && (free != '0);
  assign append  = in_write && accept &&
                   !frame_sof_i && (free != '0);
  assign wen   = begin_f || restart || append;
  assign waddr = restart ? commit_ptr[ADDR_W-1:0]
                         : wr_ptr[ADDR_W-1:0];

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      free_ptr      <= '0;
      start_ptr     <= '0;
      len           <= '0;
      frame_grant_o <= 1'b0;
      stat_ok_o     <= '0;
      stat_drop_o   <= '0;
    end else begin
      frame_grant_o <= (free > P'(GRANT_MARGIN));
      if (release_i)
        free_ptr <= free_ptr + P'(release_len_i);
      unique case (state)
        IDLE: begin
          if (accept && frame_sof_i) begin
            if (free != '0) begin
              start_ptr <= wr_ptr[ADDR_W-1:0];
              wr_ptr    <= wr_ptr + 1'b1;
              len       <= 11'd1;
              state     <= WRITE;
            end else begin
              state <= DROP;
            end
          end
        end
        WRITE: begin
          if (frame_eof_i) begin
            if (good) begin
              commit_ptr <= wr_ptr;
              if (stat_ok_o != '1)
                stat_ok_o <= stat_ok_o + 1'b1;
            end else begin
              wr_ptr <= commit_ptr;
              if (stat_drop_o != '1)
                stat_drop_o <= stat_drop_o + 1'b1;
            end
            state <= IDLE;
          end else if (accept) begin
            if (frame_sof_i) begin
              start_ptr <= commit_ptr[ADDR_W-1:0];
              wr_ptr    <= commit_ptr + 1'b1;
              len       <= 11'd1;
              if (stat_drop_o != '1)
                stat_drop_o <= stat_drop_o + 1'b1;
            end else if (free == '0) begin
              state <= DROP;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              if (len != 11'h7ff)
                len <= len + 1'b1;
            end
          end
        end
        DROP: begin
          if (frame_eof_i) begin
            wr_ptr <= commit_ptr;
            if (stat_drop_o != '1)
              stat_drop_o <= stat_drop_o + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge switch_clk) begin
    if (wen)
      mem[waddr] <= frame_data_i;
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n)
      rd_data_o <= '0;
    else
      rd_data_o <= mem[rd_addr_i];
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      d_wr <= '0;
      d_rd <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        d_start[i] <= '0;
        d_len[i]   <= '0;
        d_dst[i]   <= '0;
        d_src[i]   <= '0;
      end
    end else begin
      if (good) begin
        d_start[d_wr[DW-1:0]] <= start_ptr;
        d_len[d_wr[DW-1:0]]   <= len;
        d_dst[d_wr[DW-1:0]]   <= mac_dst_addr_i;
        d_src[d_wr[DW-1:0]]   <= mac_src_addr_i;
        d_wr <= d_wr + 1'b1;
      end
      if (pop)
        d_rd <= d_rd + 1'b1;
    end
  end

  assign desc_start_o = d_start[d_rd[DW-1:0]];
  assign desc_len_o   = d_len[d_rd[DW-1:0]];
  assign desc_dst_o   = d_dst[d_rd[DW-1:0]];
  assign desc_src_o   = d_src[d_rd[DW-1:0]];

  always @(posedge switch_clk) begin
    if (switch_rst_n && release_i)
      assert (int'(release_len_i) <= int'(used));
  end

endmodule

// File: tb/tb_rx_frame_buffer_writer.sv
// Bench for rx_frame_buffer_writer: directed frames, descriptor
// scoreboard with a decoupled monitor, read-back and stat checks.
module tb_rx_frame_buffer_writer;

  logic        switch_clk = 1'b0;
  logic        switch_rst_n = 1'b0;
  logic [7:0]  frame_data_i = '0;
  logic        frame_valid_i = 1'b0;
  logic        frame_sof_i = 1'b0;
  logic        frame_eof_i = 1'b0;
  logic        frame_error_i = 1'b0;
  logic [47:0] mac_dst_addr_i = '0;
  logic [47:0] mac_src_addr_i = '0;
  logic        frame_grant_o;
  logic        desc_valid_o;
  logic        desc_ready_i = 1'b1;
  logic [10:0] desc_start_o;
  logic [10:0] desc_len_o;
  logic [47:0] desc_dst_o;
  logic [47:0] desc_src_o;
  logic [10:0] rd_addr_i = '0;
  logic [7:0]  rd_data_o;
  logic        release_i = 1'b0;
  logic [10:0] release_len_i = '0;
  logic [15:0] stat_ok_o;
  logic [15:0] stat_drop_o;

  rx_frame_buffer_writer dut (
    .switch_clk     (switch_clk),
    .switch_rst_n   (switch_rst_n),
    .frame_data_i   (frame_data_i),
    .frame_valid_i  (frame_valid_i),
    .frame_sof_i    (frame_sof_i),
    .frame_eof_i    (frame_eof_i),
    .frame_error_i  (frame_error_i),
    .mac_dst_addr_i (mac_dst_addr_i),
    .mac_src_addr_i (mac_src_addr_i),
    .frame_grant_o  (frame_grant_o),
    .desc_valid_o   (desc_valid_o),
    .desc_ready_i   (desc_ready_i),
    .desc_start_o   (desc_start_o),
    .desc_len_o     (desc_len_o),
    .desc_dst_o     (desc_dst_o),
    .desc_src_o     (desc_src_o),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .release_i      (release_i),
    .release_len_i  (release_len_i),
    .stat_ok_o      (stat_ok_o),
    .stat_drop_o    (stat_drop_o)
  );

  always #5 switch_clk = ~switch_clk;

  typedef struct {
    logic [10:0] start;
    logic [10:0] len;
    logic [47:0] da;
    logic [47:0] sa;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [47:0] DA = 48'h0011_2233_4455;
  localparam logic [47:0] SA = 48'h6677_8899_aabb;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // monitor: pop expected descriptor on each handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge switch_clk);
      #1;
      if (desc_valid_o && desc_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL desc_unexpected: got start %0d len %0d expected none",
                   desc_start_o, desc_len_o);
        end else begin
          e = q.pop_front();
          chk("desc_start", 64'(desc_start_o), 64'(e.start));
          chk("desc_len", 64'(desc_len_o), 64'(e.len));
          chk("desc_dst", 64'(desc_dst_o), 64'(e.da));
          chk("desc_src", 64'(desc_src_o), 64'(e.sa));
        end
      end
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic s);
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge switch_clk);
      frame_data_i  = d;
      frame_sof_i   = s;
      frame_valid_i = 1'b1;
      if (frame_grant_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("put_byte_grant");
  endtask

  task automatic send_eof(input logic err);
    @(negedge switch_clk);
    frame_valid_i = 1'b0;
    frame_sof_i   = 1'b0;
    frame_eof_i   = 1'b1;
    frame_error_i = err;
    @(negedge switch_clk);
    frame_eof_i   = 1'b0;
    frame_error_i = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base,
                            input logic [47:0] da,
                            input logic [47:0] sa,
                            input logic err, input logic good,
                            input logic [10:0] start);
    mac_dst_addr_i = da;
    mac_src_addr_i = sa;
    if (good) q.push_back('{start, 11'(n), da, sa});
    for (int i = 0; i < n; i++)
      put_byte(base + 8'(i), i == 0);
    send_eof(err);
  endtask

  task automatic rd_check(input int addr, input logic [7:0] exp);
    @(negedge switch_clk);
    rd_addr_i = 11'(addr);
    @(negedge switch_clk);
    chk("rd_data", 64'(rd_data_o), 64'(exp));
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && q.size() != 0; t++)
      @(negedge switch_clk);
    if (q.size() != 0) bound_fail(name);
  endtask

  task automatic do_reset();
    @(negedge switch_clk);
    switch_rst_n  = 1'b0;
    frame_valid_i = 1'b0;
    frame_sof_i   = 1'b0;
    frame_eof_i   = 1'b0;
    frame_error_i = 1'b0;
    release_i     = 1'b0;
    q.delete();
    #1;
    chk("rst_grant", 64'(frame_grant_o), 64'd0);
    chk("rst_desc_valid", 64'(desc_valid_o), 64'd0);
    repeat (2) @(negedge switch_clk);
    switch_rst_n = 1'b1;
    @(negedge switch_clk);
    chk("post_rst_grant", 64'(frame_grant_o), 64'd1);
  endtask

  initial begin
    int idx;
    #1;
    chk("init_grant", 64'(frame_grant_o), 64'd0);
    chk("init_desc_valid", 64'(desc_valid_o), 64'd0);
    chk("init_desc_len", 64'(desc_len_o), 64'd0);
    chk("init_rd_data", 64'(rd_data_o), 64'd0);
    chk("init_stat_ok", 64'(stat_ok_o), 64'd0);
    chk("init_stat_drop", 64'(stat_drop_o), 64'd0);
    repeat (2) @(negedge switch_clk);
    switch_rst_n = 1'b1;
    @(negedge switch_clk);
    chk("first_grant", 64'(frame_grant_o), 64'd1);

    // single minimum-size good frame
    send_frame(64, 8'h00, DA, SA, 1'b0, 1'b1, 11'd0);
    chk("t1_desc_latency", 64'(desc_valid_o), 64'd1);
    for (int i = 0; i < 64; i += 7)
      rd_check(i, 8'(i));
    rd_check(63, 8'h3f);
    drain("t1_drain");
    chk("t1_ok", 64'(stat_ok_o), 64'd1);
    chk("t1_drop", 64'(stat_drop_o), 64'd0);

    // errored frame rewound, next frame reuses address 0
    do_reset();
    send_frame(100, 8'h10, DA, SA, 1'b1, 1'b0, 11'd0);
    chk("t2_no_desc", 64'(desc_valid_o), 64'd0);
    send_frame(70, 8'h40, DA + 1, SA + 1, 1'b0, 1'b1, 11'd0);
    rd_check(0, 8'h40);
    rd_check(69, 8'h85);
    drain("t2_drain");
    chk("t2_ok", 64'(stat_ok_o), 64'd1);
    chk("t2_drop", 64'(stat_drop_o), 64'd1);

    // runts, missing eof restart, then good frame at 0
    do_reset();
    send_frame(40, 8'h90, DA, SA, 1'b0, 1'b0, 11'd0);
    chk("t3_no_desc", 64'(desc_valid_o), 64'd0);
    chk("t3_drop40", 64'(stat_drop_o), 64'd1);
    send_frame(63, 8'ha0, DA, SA, 1'b0, 1'b0, 11'd0);
    chk("t3_drop63", 64'(stat_drop_o), 64'd2);
    for (int i = 0; i < 20; i++)
      put_byte(8'h11, i == 0);
    send_frame(64, 8'hc0, DA + 3, SA + 3, 1'b0, 1'b1, 11'd0);
    rd_check(63, 8'hff);
    rd_check(0, 8'hc0);
    drain("t3_drain");
    chk("t3_ok", 64'(stat_ok_o), 64'd1);
    chk("t3_drop", 64'(stat_drop_o), 64'd3);

    // fill, grant back-pressure, release, wrap
    do_reset();
    send_frame(1000, 8'h00, DA, SA, 1'b0, 1'b1, 11'd0);
    send_frame(1000, 8'h55, DA + 7, SA + 7, 1'b0, 1'b1, 11'd1000);
    q.push_back('{11'd2000, 11'd100, DA + 9, SA + 9});
    mac_dst_addr_i = DA + 9;
    mac_src_addr_i = SA + 9;
    idx = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge switch_clk);
      if (!frame_grant_o) begin
        frame_valid_i = 1'b0;
        break;
      end
      frame_data_i  = 8'h80 + 8'(idx);
      frame_sof_i   = (idx == 0);
      frame_valid_i = 1'b1;
      idx++;
    end
    chk("t4_bytes_before_stall", 64'(idx), 64'd45);
    chk("t4_grant_low", 64'(frame_grant_o), 64'd0);
    release_i     = 1'b1;
    release_len_i = 11'd1000;
    @(negedge switch_clk);
    release_i = 1'b0;
    chk("t4_grant_rel1", 64'(frame_grant_o), 64'd0);
    @(negedge switch_clk);
    chk("t4_grant_rel2", 64'(frame_grant_o), 64'd1);
    for (int i = 45; i < 100; i++)
      put_byte(8'h80 + 8'(i), 1'b0);
    send_eof(1'b0);
    rd_check(2047, 8'haf);
    rd_check(0, 8'hb0);
    rd_check(51, 8'he3);
    drain("t4_drain");
    chk("t4_ok", 64'(stat_ok_o), 64'd3);

    // descriptor FIFO full: ninth frame dropped
    do_reset();
    desc_ready_i = 1'b0;
    for (int k = 0; k < 9; k++)
      send_frame(64, 8'(k * 16), DA + 48'(k), SA, 1'b0,
                 k < 8, 11'(k * 64));
    chk("t5_ok", 64'(stat_ok_o), 64'd8);
    chk("t5_drop", 64'(stat_drop_o), 64'd1);
    chk("t5_valid_held", 64'(desc_valid_o), 64'd1);
    desc_ready_i = 1'b1;
    drain("t5_drain");
    @(negedge switch_clk);
    chk("t5_empty", 64'(desc_valid_o), 64'd0);

    // reset mid-frame discards queued descriptor and data
    do_reset();
    desc_ready_i = 1'b0;
    send_frame(64, 8'h20, DA, SA, 1'b0, 1'b1, 11'd0);
    for (int i = 0; i < 30; i++)
      put_byte(8'h70 + 8'(i), i == 0);
    do_reset();
    chk("t6_valid_after_rst", 64'(desc_valid_o), 64'd0);
    chk("t6_ok_after_rst", 64'(stat_ok_o), 64'd0);
    desc_ready_i = 1'b1;
    send_frame(64, 8'h33, DA + 5, SA + 5, 1'b0, 1'b1, 11'd0);
    drain("t6_drain");
    chk("t6_ok", 64'(stat_ok_o), 64'd1);
    chk("t6_drop", 64'(stat_drop_o), 64'd0);
    rd_check(0, 8'h33);

    repeat (4) @(negedge switch_clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
